preprocess_ctrl: RTL and testbench
==================================

Name: preprocess_ctrl

Overview:
- Frame-level sequencer for the 3-row line-buffer preprocess stage.
- Issues linear pixel reads to the memory controller:
  - a 3-row prefill;
  - then one new row per output row.
- Tracks read returns. Raises core_run for exactly one window sweep per output row and ends the sweep on the stage's core_done pulse.
- Sits between the top-level controller (start/done) and the memory controller and preprocess stage.

Parameters:
- MAX_ROW, 540: image rows.
- MAX_COL, 540: image columns; one window sweep is MAX_COL-2 cycles.
- ADDR_W, 19: pixel address width; must hold MAX_ROW*MAX_COL-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  frame start pulse; honoured only in IDLE.
- base_addr_i  in  ADDR_W  frame base address; sampled on accepted start_i.
- mem_rd_en_o  out  1  read request, one pixel.
- mem_addr_o  out  ADDR_W  read address.
- mem_ready_i  in  1  memory accepts request this cycle.
- mem_rd_valid_i  in  1  read data returned (same strobe feeds preprocess data_en).
- core_run_o  out  1  window sweep enable to preprocess.
- core_done_i  in  1  last-column pulse from preprocess.
- out_row_o  out  10  index of output row being swept, 0..MAX_ROW-3.
- row_phase_o  out  2  buffer index (0..2) holding the oldest row of the current window.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle frame-complete pulse.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (synchronous, rst=1): state IDLE; every output 0; all counters 0; err_o cleared.
- States: IDLE, FILL, RUN, LOAD, DONE.
- IDLE:
  - start_i=1 latches base_addr_i into the address counter, clears the issue/return counters and out_row, sets row_phase=0, and moves to FILL.
- Request channel (FILL and LOAD):
  - mem_rd_en_o=1 while issued < target.
  - A request is accepted when mem_rd_en_o & mem_ready_i. On acceptance, mem_addr_o increments by 1 and the issued count increments.
  - mem_addr_o is registered and always equals the address of the pending request.
- Return channel:
  - Each mem_rd_valid_i increments the returned count.
  - A state exits when returned == target; the transition takes effect the cycle after the last valid.
- Targets:
  - FILL: 3*MAX_COL. FILL then goes to RUN.
  - LOAD: MAX_COL. LOAD then goes to RUN and increments row_phase mod 3.
- RUN:
  - core_run_o=1 from the first RUN cycle.
  - When core_run_o & core_done_i:
    - if out_row == MAX_ROW-3, go to DONE;
    - otherwise increment out_row, go to LOAD, and drop core_run_o next cycle.
  - Nominal sweep length is MAX_COL-2 cycles. Reaching 2*MAX_COL RUN cycles without core_done_i sets err_o and forces LOAD/DONE as if done had arrived.
- DONE: done_o=1 for one cycle, then IDLE. busy_o=0 in that IDLE cycle.
- Boundary conditions:
  - start_i outside IDLE: ignored.
  - core_done_i outside RUN: ignored and sets err_o.
  - mem_rd_valid_i when returned == target, or in IDLE/RUN/DONE: sets err_o and is not counted.
  - mem_ready_i low: the request holds, with address and enable stable.
  - start_i in the same cycle as done_o: ignored, because the FSM is not yet in IDLE.
  - rst mid-frame: immediate return to IDLE with outputs 0. Read returns still in flight after reset are ignored without setting err_o, since err_o is cleared by reset.
- Totals: issued reads per frame = MAX_ROW*MAX_COL; core_run_o high cycles per frame = (MAX_ROW-2)*(MAX_COL-2).

Optional Feature:
- Macro PRE_CTRL_PERF_EN.
- Defined: adds output port frame_cycles_o [31:0], which counts cycles from accepted start to the DONE state.
  - Holds its value after done_o.
  - Cleared on the next accepted start and on rst.
- Undefined: no port, no counter; all other behaviour is identical.

Test Plan (MAX_ROW=5, MAX_COL=6, ADDR_W=8, memory latency 1, ready=1, preprocess model returns done on the 4th run cycle):
- Nominal frame, base 0x10 -> 30 reads at addresses 0x10..0x2D in order; core_run_o high in 3 bursts of 4 cycles; out_row_o 0,1,2; row_phase_o 0,1,2; single done_o pulse; err_o=0.
- mem_ready_i toggled 1/0 every cycle -> address sequence identical to the nominal case with no duplicates or skips; FSM still completes; done_o=1 once.
- start_i pulsed during FILL and again during RUN -> both ignored; base address unchanged; exactly 30 reads.
- Extra mem_rd_valid_i injected in RUN -> err_o=1 and stays 1; frame completes normally; cleared only by rst.
- rst asserted for 1 cycle during the second RUN -> next cycle: IDLE, all outputs 0; a new start_i with base 0x40 produces a full clean frame starting at 0x40.
- PRE_CTRL_PERF_EN defined, nominal frame -> frame_cycles_o equals the bench-measured start-to-done count and holds after done_o.

Source files
------------

// File: rtl/preprocess_ctrl.sv
// preprocess_ctrl: frame sequencer for the 3-row line-buffer preprocess stage
// Ports:
//   clk, rst                   system clock, synchronous active-high reset
//   start_i, base_addr_i       frame start pulse and frame base address (honoured in IDLE only)
//   mem_rd_en_o, mem_addr_o    linear single-pixel read requests, held until mem_ready_i
//   mem_ready_i                memory accepts the pending request this cycle
//   mem_rd_valid_i             read data return strobe
//   core_run_o, core_done_i    one window sweep per output row, ended by the stage's last-column pulse
//   out_row_o, row_phase_o     output row being swept, buffer index holding the oldest window row
//   busy_o, done_o, err_o      not-idle flag, one-cycle frame-complete pulse, sticky protocol error
//   frame_cycles_o             start-to-done cycle count, present only with PRE_CTRL_PERF_EN defined
module preprocess_ctrl #(
    parameter int MAX_ROW = 540,
    parameter int MAX_COL = 540,
    parameter int ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_rd_valid_i,
    output logic              core_run_o,
    input  logic              core_done_i,
    output logic [9:0]        out_row_o,
    output logic [1:0]        row_phase_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
`ifdef PRE_CTRL_PERF_EN
    ,
    output logic [31:0]       frame_cycles_o
`endif
);
    localparam int CNT_W = $clog2(3 * MAX_COL + 1);
    localparam int RUN_W = $clog2(2 * MAX_COL + 1);
    localparam logic [CNT_W-1:0] FILL_T   = CNT_W'(3 * MAX_COL);
    localparam logic [CNT_W-1:0] LOAD_T   = CNT_W'(MAX_COL);
    localparam logic [RUN_W-1:0] RUN_LIM  = RUN_W'(2 * MAX_COL - 1);
    localparam logic [9:0]       LAST_ROW = 10'(MAX_ROW - 3);

    typedef enum logic [2:0] {IDLE, FILL, RUN, LOAD, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] issued, returned, target;
    logic [RUN_W-1:0] run_cnt;
    logic             quiet, in_req, take, ret_ok, timeout, sweep_end, bad;

    always_comb begin
        in_req      = state == FILL || state == LOAD;
        target      = state == FILL ? FILL_T : LOAD_T;
        mem_rd_en_o = in_req && issued < target;
        take        = mem_rd_en_o && mem_ready_i;
        ret_ok      = in_req && mem_rd_valid_i && returned < target;
        timeout     = state == RUN && run_cnt == RUN_LIM;
        sweep_end   = state == RUN && (core_done_i || timeout);
        core_run_o  = state == RUN;
        busy_o      = state != IDLE;
        done_o      = state == DONE;
        // quiet covers IDLE after reset, where returns of an aborted frame may still arrive
        bad         = (mem_rd_valid_i && !ret_ok && !(state == IDLE && quiet))
                    || (core_done_i && state != RUN)
                    || (timeout && !core_done_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_addr_o  <= '0;
            issued      <= '0;
            returned    <= '0;
            run_cnt     <= '0;
            out_row_o   <= '0;
            row_phase_o <= '0;
            err_o       <= 1'b0;
            quiet       <= 1'b1;
        end else begin
            if (bad)
                err_o <= 1'b1;
            if (take) begin
                mem_addr_o <= mem_addr_o + 1'b1;
                issued     <= issued + 1'b1;
            end
            if (ret_ok)
                returned <= returned + 1'b1;
            case (state)
                IDLE: if (start_i) begin
                    state       <= FILL;
                    mem_addr_o  <= base_addr_i;
                    issued      <= '0;
                    returned    <= '0;
                    out_row_o   <= '0;
                    row_phase_o <= '0;
                    quiet       <= 1'b0;
                end
                FILL, LOAD: if (ret_ok && returned == target - 1'b1) begin
                    // every request was issued before its return, so the counters restart cleanly
                    state    <= RUN;
                    issued   <= '0;
                    returned <= '0;
                    run_cnt  <= '0;
                    if (state == LOAD)
                        row_phase_o <= row_phase_o == 2'd2 ? 2'd0 : row_phase_o + 2'd1;
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (sweep_end) begin
                        if (out_row_o == LAST_ROW)
                            state <= DONE;
                        else begin
                            state     <= LOAD;
                            out_row_o <= out_row_o + 10'd1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            frame_cycles_o <= '0;
        else if (state == IDLE && start_i)
            frame_cycles_o <= '0;
        else if (state == FILL || state == RUN || state == LOAD)
            frame_cycles_o <= frame_cycles_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_preprocess_ctrl.sv
// tb_preprocess_ctrl: directed scenario table plus hand sequences for preprocess_ctrl
module tb_preprocess_ctrl;
    logic       clk = 0, rst = 0, start_i = 0, mem_ready_i = 1, mem_rd_valid_i = 0, core_done_i = 0;
    logic [7:0] base_addr_i = 0;
    logic       mem_rd_en_o, core_run_o, busy_o, done_o, err_o;
    logic [7:0] mem_addr_o;
    logic [9:0] out_row_o;
    logic [1:0] row_phase_o;
`ifdef PRE_CTRL_PERF_EN
    logic [31:0] frame_cycles_o;
`endif

    preprocess_ctrl #(.MAX_ROW(5), .MAX_COL(6), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
        .mem_rd_valid_i(mem_rd_valid_i), .core_run_o(core_run_o), .core_done_i(core_done_i),
        .out_row_o(out_row_o), .row_phase_o(row_phase_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o)
`ifdef PRE_CTRL_PERF_EN
        , .frame_cycles_o(frame_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        bit tog, st_fill, st_run, st_done, inj, nodone;
        int exp_reads, exp_runhi, exp_bursts, exp_err;
    } vec_t;

    vec_t       vec[5];
    vec_t       cur;
    logic [7:0] addrs[$];
    int         b_row[8], b_ph[8];
    int         rc, run_hi, bursts, dones, fc, nchk, nfail;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, int'({busy_o, core_run_o, mem_rd_en_o, done_o, err_o, out_row_o, row_phase_o, mem_addr_o}), 0);
    endtask

    task automatic clr();
        addrs.delete();
        rc = 0; run_hi = 0; bursts = 0; dones = 0; fc = 0;
    endtask

    // one clock: log accepted address, return it one cycle later, model the sweep stage
    task automatic cycle();
        logic       acc;
        logic [7:0] a;
        acc = mem_rd_en_o && mem_ready_i;
        a   = mem_addr_o;
        @(posedge clk);
        #1;
        start_i = 0;
        if (acc) addrs.push_back(a);
        mem_rd_valid_i = acc;
        if (core_run_o) begin
            rc++;
            run_hi++;
            if (rc == 1) begin
                if (bursts < 8) begin
                    b_row[bursts] = int'(out_row_o);
                    b_ph[bursts]  = int'(row_phase_o);
                end
                bursts++;
            end
            if (cur.inj && rc == 2 && bursts == 2) mem_rd_valid_i = 1;
            if (cur.st_run && rc == 1 && bursts == 1) begin
                start_i = 1;
                base_addr_i = 8'h99;
            end
        end else rc = 0;
        core_done_i = core_run_o && rc == 4 && !cur.nodone;
        if (busy_o && !done_o) fc++;
        if (cur.st_fill && fc == 3) begin
            start_i = 1;
            base_addr_i = 8'h99;
        end
        if (done_o) begin
            dones++;
            if (cur.st_done) start_i = 1;
        end
        mem_ready_i = cur.tog ? !mem_ready_i : 1'b1;
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    task automatic run_frame(input logic [7:0] base);
        int bad;
        clr();
        start_i = 1;
        base_addr_i = base;
        cycle();
        for (int i = 0; i < 2000 && dones == 0; i++) cycle();
        chk("frame_done_reached", dones, 1);
`ifdef PRE_CTRL_PERF_EN
        chk("perf_at_done", int'(frame_cycles_o), fc);
`endif
        cycle();
        chk("idle_after_done", int'({busy_o, done_o, mem_rd_en_o}), 0);
`ifdef PRE_CTRL_PERF_EN
        chk("perf_hold", int'(frame_cycles_o), fc);
`endif
        bad = 0;
        foreach (addrs[i]) if (addrs[i] != 8'(base + i)) bad++;
        chk("addr_seq", bad, 0);
        bad = 0;
        for (int j = 0; j < 3; j++) if (b_row[j] != j || b_ph[j] != j) bad++;
        chk("row_phase_seq", bad, 0);
    endtask

    initial begin
        nchk = 0;
        nfail = 0;
        //           base   tog st_fill st_run st_done inj nodone reads runhi bursts err
        vec[0] = '{8'h10, 0, 0, 0, 0, 0, 0, 30, 12, 3, 0};
        vec[1] = '{8'h10, 1, 0, 0, 1, 0, 0, 30, 12, 3, 0};
        vec[2] = '{8'h10, 0, 1, 1, 0, 0, 0, 30, 12, 3, 0};
        vec[3] = '{8'h10, 0, 0, 0, 0, 1, 0, 30, 12, 3, 1};
        vec[4] = '{8'h30, 0, 0, 0, 0, 0, 1, 30, 36, 3, 1};
        cur = vec[0];

        do_reset();
        chk_idle("reset_outputs");
        mem_rd_valid_i = 1;
        cycle();
        chk("stray_valid_after_rst", int'(err_o), 0);
        core_done_i = 1;
        cycle();
        chk("core_done_in_idle_err", int'(err_o), 1);

        for (int k = 0; k < 5; k++) begin
            cur = vec[k];
            do_reset();
            chk("err_clr_by_rst", int'(err_o), 0);
            run_frame(cur.base);
            chk("reads", addrs.size(), cur.exp_reads);
            chk("run_cycles", run_hi, cur.exp_runhi);
            chk("bursts", bursts, cur.exp_bursts);
            chk("err_end", int'(err_o), cur.exp_err);
            if (cur.st_done) begin
                repeat (3) cycle();
                chk("start_at_done_ignored", int'(busy_o), 0);
                chk("single_done", dones, 1);
            end
        end

        cur = vec[0];
        do_reset();
        clr();
        start_i = 1;
        base_addr_i = 8'h20;
        cycle();
        for (int i = 0; i < 500 && !(bursts == 2 && rc == 1); i++) cycle();
        chk("reached_run2", bursts, 2);
        rst = 1;
        cycle();
        rst = 0;
        chk_idle("mid_frame_reset");
        run_frame(8'h40);
        chk("post_rst_reads", addrs.size(), 30);
        chk("post_rst_first_addr", addrs.size() > 0 ? int'(addrs[0]) : -1, 8'h40);
        chk("post_rst_run_cycles", run_hi, 12);
        chk("post_rst_err", int'(err_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
